// File: rtl/axi_ad7124_frame_buf.sv
// axi_ad7124_frame_buf
// Ping-pong frame capture buffer between the AD7124 SPI offload byte stream
// (clk domain) and an AXI BRAM controller read port (bram_clk domain).
// One bank fills with the current frame while the host reads the last
// complete frame from the other bank. Counts completed frames and flags
// frames cut short by a new trigger.
//
// Optional feature macro: AXI_AD7124_FRAME_SEQ_EN
//   When defined, each bank carries a sequence tag. The tag is readable at
//   word address all-ones of the exposed bank.
module axi_ad7124_frame_buf #(
   parameter int BUFFER_ADDR_WIDTH = 5,
   parameter int FRAME_LENGTH      = 32,
   parameter int FRAME_CNT_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         trigger,
   output logic                         drdy,
   output logic                         frame_err,
   output logic [FRAME_CNT_WIDTH-1:0]   frame_cnt,
   output logic                         rd_bank,
   input  logic                         offload_sdi_valid,
   output logic                         offload_sdi_ready,
   input  logic [7:0]                   offload_sdi_data,
   input  logic                         bram_clk,
   input  logic                         bram_rst,
   input  logic                         bram_en,
   input  logic [BUFFER_ADDR_WIDTH-3:0] bram_addr,
   output logic [31:0]                  bram_dout
);

   // Words per bank; the RAM is split into four byte lanes so that a whole
   // 32-bit word can be read in one access. Lane 0 holds the first byte of
   // each word and drives bram_dout[31:24].
   localparam int WORD_AW    = BUFFER_ADDR_WIDTH - 2;
   localparam int BANK_WORDS = 2 ** WORD_AW;
   localparam logic [BUFFER_ADDR_WIDTH-1:0] LAST_CNT = BUFFER_ADDR_WIDTH'(FRAME_LENGTH - 1);

   // Parameter legality, caught at elaboration
   generate
      if (FRAME_LENGTH < 1 || FRAME_LENGTH > 2 ** BUFFER_ADDR_WIDTH) begin : g_len_chk
         $error("FRAME_LENGTH must be within 1..2**BUFFER_ADDR_WIDTH");
      end
`ifdef AXI_AD7124_FRAME_SEQ_EN
      if (FRAME_LENGTH > 2 ** BUFFER_ADDR_WIDTH - 4) begin : g_seq_len_chk
         $error("FRAME_LENGTH must leave the last word of a bank free for the sequence tag");
      end
      if (FRAME_CNT_WIDTH > 32) begin : g_seq_cnt_chk
         $error("FRAME_CNT_WIDTH must fit in the 32-bit tag word");
      end
`endif
   endgenerate

   // ------------------------------------------------------------------
   // Write side (clk domain)
   // ------------------------------------------------------------------
   logic                         wr_bank_r;
   logic                         rd_bank_r;
   logic [BUFFER_ADDR_WIDTH-1:0] wr_cnt_r;
   logic [FRAME_CNT_WIDTH-1:0]   frame_cnt_r;
   logic                         drdy_r;
   logic                         frame_err_r;

   logic [BUFFER_ADDR_WIDTH-1:0] eff_cnt_s;
   logic                         frame_done_s;
   logic                         wr_en_s;
   logic [1:0]                   wr_lane_s;
   logic [WORD_AW:0]             wr_word_s;

   logic [7:0] mem_r [4][2*BANK_WORDS];

   // A trigger restarts the frame, so a byte arriving with it lands at offset 0
   always_comb begin
      if (trigger) begin
         eff_cnt_s = '0;
      end else begin
         eff_cnt_s = wr_cnt_r;
      end
      wr_en_s      = resetn & offload_sdi_valid;
      frame_done_s = wr_en_s && (eff_cnt_s == LAST_CNT);
      wr_lane_s    = eff_cnt_s[1:0];
      wr_word_s    = {wr_bank_r, eff_cnt_s[BUFFER_ADDR_WIDTH-1:2]};
   end

   // Byte-lane RAM write port
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_lane_s][wr_word_s] <= offload_sdi_data;
      end
   end

   // Frame sequencing: byte counter, bank swap, frame counter and status pulses
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_bank_r   <= 1'b0;
         rd_bank_r   <= 1'b1;
         wr_cnt_r    <= '0;
         frame_cnt_r <= '0;
         drdy_r      <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         drdy_r      <= frame_done_s;
         frame_err_r <= trigger && (wr_cnt_r != '0);
         if (frame_done_s) begin
            wr_cnt_r    <= '0;
            rd_bank_r   <= wr_bank_r;
            wr_bank_r   <= ~wr_bank_r;
            frame_cnt_r <= frame_cnt_r + FRAME_CNT_WIDTH'(1);
         end else if (offload_sdi_valid) begin
            wr_cnt_r <= eff_cnt_s + BUFFER_ADDR_WIDTH'(1);
         end else if (trigger) begin
            wr_cnt_r <= '0;
         end
      end
   end

`ifdef AXI_AD7124_FRAME_SEQ_EN
   logic [FRAME_CNT_WIDTH-1:0] tag_r [2];

   // Stamp the filled bank with the frame number it becomes when exposed
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tag_r[0] <= '0;
         tag_r[1] <= '0;
      end else if (frame_done_s) begin
         tag_r[wr_bank_r] <= frame_cnt_r + FRAME_CNT_WIDTH'(1);
      end
   end
`endif

   assign drdy              = drdy_r;
   assign frame_err         = frame_err_r;
   assign frame_cnt         = frame_cnt_r;
   assign rd_bank           = rd_bank_r;
   assign offload_sdi_ready = 1'b1;

   // ------------------------------------------------------------------
   // Read side (bram_clk domain)
   // ------------------------------------------------------------------
   logic               rd_bank_m_r;
   logic               rd_bank_s_r;
   logic [WORD_AW:0]   rd_word_s;
   logic [31:0]        rd_data_s;
   logic [31:0]        bram_dout_r;

   // Two-flop synchroniser carrying the exposed bank into bram_clk
   always_ff @(posedge bram_clk) begin
      if (bram_rst) begin
         rd_bank_m_r <= 1'b1;
         rd_bank_s_r <= 1'b1;
      end else begin
         rd_bank_m_r <= rd_bank_r;
         rd_bank_s_r <= rd_bank_m_r;
      end
   end

   // Assemble the word: first byte of the word in the top byte
   always_comb begin
      rd_word_s = {rd_bank_s_r, bram_addr};
`ifdef AXI_AD7124_FRAME_SEQ_EN
      if (&bram_addr) begin
         rd_data_s = 32'(tag_r[rd_bank_s_r]);
      end else begin
         rd_data_s = {mem_r[0][rd_word_s], mem_r[1][rd_word_s],
                      mem_r[2][rd_word_s], mem_r[3][rd_word_s]};
      end
`else
      rd_data_s = {mem_r[0][rd_word_s], mem_r[1][rd_word_s],
                   mem_r[2][rd_word_s], mem_r[3][rd_word_s]};
`endif
   end

   // Registered read data, one cycle latency, holds while bram_en is low
   always_ff @(posedge bram_clk) begin
      if (bram_rst) begin
         bram_dout_r <= 32'h0000_0000;
      end else if (bram_en) begin
         bram_dout_r <= rd_data_s;
      end
   end

   assign bram_dout = bram_dout_r;

endmodule
